// File: rtl/timer_pkg.sv
// Shared constants and types for the 8-bit timer APB register block.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  localparam int LOAD_B  = 7;
  localparam int DW_B    = 5;
  localparam int EN_B    = 4;
  localparam int CKS_LSB = 0;

  localparam int UDF_B = 1;
  localparam int OVF_B = 0;

  // Bits 6, 3 and 2 of TCR are reserved and are never stored.
  localparam logic [7:0] TCR_MASK = 8'hB3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

endpackage

// File: rtl/timer_tsr_flag.sv
// Sticky status bit: a set pulse wins over a write-0 clear in the same cycle.
module timer_tsr_flag (
  input  logic pclk,
  input  logic preset,
  input  logic set,
  input  logic clr,
  output logic flag
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)   flag <= 1'b0;
    else if (set) flag <= 1'b1;
    else if (clr) flag <= 1'b0;
  end

endmodule

// File: rtl/timer_apb_responder.sv
// APB completer and register file (TDR/TCR/TSR/TCNT) for the 8-bit timer core.
module timer_apb_responder
  import timer_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              dw_o,
  output logic              en_o,
  output logic [1:0]        cks_o,
  input  logic [7:0]        cnt_i,
  input  logic              ovf_set_i,
  input  logic              udf_set_i
);

  state_e     state_q, state_nxt;
  logic [2:0] wcnt_q;
  logic [7:0] tdr_q, tcr_q;
  logic       ovf_flag, udf_flag;

  logic       sel_tdr, sel_tcr, sel_tsr, sel_tcnt, addr_err;
  logic [7:0] rd_mux;
  logic       raise_ready, wr_commit, wr_tsr;

  // Address decode and read mux over stored register values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rd_mux   = 8'h00;
    sel_tdr  = (paddr == ADDR_W'(ADDR_TDR));
    sel_tcr  = (paddr == ADDR_W'(ADDR_TCR));
    sel_tsr  = (paddr == ADDR_W'(ADDR_TSR));
    sel_tcnt = (paddr == ADDR_W'(ADDR_TCNT));
    addr_err = !(sel_tdr || sel_tcr || sel_tsr || sel_tcnt);
    if (sel_tdr)  rd_mux = tdr_q;
    if (sel_tcr)  rd_mux = tcr_q;
    if (sel_tsr)  rd_mux = {6'b0, udf_flag, ovf_flag};
    if (sel_tcnt) rd_mux = cnt_i;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (psel && !penable) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = psel ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: if (!psel || pready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // pready rises once the wait-state budget is spent; a dropped psel aborts silently.
  always_comb begin
    raise_ready = 1'b0;
    wr_commit   = 1'b0;
    case (state_q)
      ST_SETUP:  raise_ready = psel && (WAIT_STATES == 0);
      ST_ACCESS: begin
        raise_ready = psel && !pready && (wcnt_q == 3'd1);
        wr_commit   = pready && psel && penable && pwrite;
      end
      default: ;
    endcase
    wr_tsr = wr_commit && sel_tsr;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wcnt_q  <= 3'd0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      tdr_q   <= 8'h00;
      tcr_q   <= 8'h00;
    end else begin
      pready <= raise_ready;
      if (state_q == ST_SETUP)
        wcnt_q <= 3'(WAIT_STATES);
      else if (state_q == ST_ACCESS && !pready && wcnt_q != 3'd0)
        wcnt_q <= wcnt_q - 3'd1;
      if (raise_ready) begin
        pslverr <= addr_err;
        prdata  <= pwrite ? '0 : DATA_W'(rd_mux);
      end
      if (wr_commit && sel_tdr) tdr_q <= pwdata[7:0];
      if (wr_commit && sel_tcr) tcr_q <= pwdata[7:0] & TCR_MASK;
    end
  end

  timer_tsr_flag u_ovf (
    .pclk   (pclk),
    .preset (preset),
    .set    (ovf_set_i),
    .clr    (wr_tsr && !pwdata[OVF_B]),
    .flag   (ovf_flag)
  );

  timer_tsr_flag u_udf (
    .pclk   (pclk),
    .preset (preset),
    .set    (udf_set_i),
    .clr    (wr_tsr && !pwdata[UDF_B]),
    .flag   (udf_flag)
  );

  assign tdr_o  = tdr_q;
  assign load_o = tcr_q[LOAD_B];
  assign dw_o   = tcr_q[DW_B];
  assign en_o   = tcr_q[EN_B];
  assign cks_o  = tcr_q[CKS_LSB +: 2];

endmodule
